// File: rtl/program_memory_loader_if.sv
// Byte-stream-in / program-memory-write-out bundle of the program memory loader.
// byte_i moves when byte_valid_i and byte_ready_o are both high on a rising clk edge; an offered byte is held by the producer until then.
interface program_memory_loader_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start_i;
   logic [7:0]            byte_i;
   logic                  byte_valid_i;
   logic                  byte_ready_o;
   logic                  mem_we_o;
   logic [DATA_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_data_o;
   logic                  cpu_hold_o;
   logic                  busy_o;
   logic                  done_o;
   logic                  error_o;
   logic [15:0]           words_written_o;
   logic [2:0]            dbg_state;

   modport master (
      output start_i, byte_i, byte_valid_i,
      input  byte_ready_o, mem_we_o, mem_addr_o, mem_data_o, cpu_hold_o,
             busy_o, done_o, error_o, words_written_o, dbg_state
   );

   modport slave (
      input  start_i, byte_i, byte_valid_i,
      output byte_ready_o, mem_we_o, mem_addr_o, mem_data_o, cpu_hold_o,
             busy_o, done_o, error_o, words_written_o, dbg_state
   );
endinterface

// File: rtl/program_memory_loader.sv
// Loads a length-prefixed little-endian program image from a byte stream into program
// memory at consecutive word addresses, holding the core in reset while loading.
module program_memory_loader #(
   parameter int                    MEMORY_DEPTH = 32,
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h00400000
) (
   input logic                   clk,
   input logic                   reset,
   program_memory_loader_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_DATA  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4,
      S_ERROR = 3'd5
   } state_t;

   localparam logic [15:0] MAX_WORDS = 16'(MEMORY_DEPTH);

   state_t                state, state_nxt;
   logic [1:0]            byte_idx;
   logic [15:0]           word_count;
   logic [15:0]           words_written;
   logic [DATA_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] data;
   logic                  byte_ready;
   logic                  mem_we;
   logic                  cpu_hold;
   logic                  busy;
   logic                  done;
   logic                  error;
   logic                  xfer;
   logic [15:0]           len_word;

   assign xfer     = bus.byte_valid_i & byte_ready;
   // Full header as it completes on the second length byte.
   assign len_word = {bus.byte_i, word_count[7:0]};

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (bus.start_i) state_nxt = S_LEN;
         end
         S_LEN: begin
            if (xfer && byte_idx == 2'd1) begin
               if (len_word == 16'd0)           state_nxt = S_DONE;
               else if (len_word > MAX_WORDS)   state_nxt = S_ERROR;
               else                             state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (xfer && byte_idx == 2'd3) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            state_nxt = (words_written + 16'd1 == word_count) ? S_DONE : S_DATA;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // All outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         byte_idx      <= 2'd0;
         word_count    <= 16'd0;
         words_written <= 16'd0;
         addr          <= BASE_ADDRESS;
         data          <= '0;
         byte_ready    <= 1'b0;
         mem_we        <= 1'b0;
         cpu_hold      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
      end else begin
         state      <= state_nxt;
         byte_ready <= (state_nxt == S_LEN) || (state_nxt == S_DATA);
         mem_we     <= (state_nxt == S_WRITE);
         busy       <= (state_nxt == S_LEN) || (state_nxt == S_DATA) || (state_nxt == S_WRITE);
         cpu_hold   <= (state_nxt == S_LEN) || (state_nxt == S_DATA) || (state_nxt == S_WRITE) ||
                       (state_nxt == S_ERROR);
         done       <= (state_nxt == S_DONE);
         error      <= (state_nxt == S_ERROR);

         unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (bus.start_i) begin
                  byte_idx      <= 2'd0;
                  word_count    <= 16'd0;
                  words_written <= 16'd0;
                  addr          <= BASE_ADDRESS;
               end
            end
            S_LEN: begin
               if (xfer) begin
                  if (byte_idx == 2'd0) begin
                     word_count[7:0] <= bus.byte_i;
                     byte_idx        <= 2'd1;
                  end else begin
                     word_count[15:8] <= bus.byte_i;
                     byte_idx         <= 2'd0;
                  end
               end
            end
            S_DATA: begin
               if (xfer) begin
                  data[{byte_idx, 3'b000} +: 8] <= bus.byte_i;
                  byte_idx                      <= byte_idx + 2'd1;
               end
            end
            S_WRITE: begin
               addr          <= addr + DATA_WIDTH'(4);
               words_written <= words_written + 16'd1;
            end
            default: begin
               byte_idx <= 2'd0;
            end
         endcase
      end
   end

   assign bus.byte_ready_o    = byte_ready;
   assign bus.mem_we_o        = mem_we;
   assign bus.mem_addr_o      = addr;
   assign bus.mem_data_o      = data;
   assign bus.cpu_hold_o      = cpu_hold;
   assign bus.busy_o          = busy;
   assign bus.done_o          = done;
   assign bus.error_o         = error;
   assign bus.words_written_o = words_written;
   assign bus.dbg_state       = state;

endmodule
